// File: rtl/decode_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_queue_pkg
//  Purpose  : Shared configuration for the decode/issue queue. Holds the
//             RV32I opcode-class constants, the ROB tag width, the immediate
//             format enum and small opcode-classification helpers.
//  Revision : 1.0  initial release
// ============================================================================
package decode_issue_queue_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL   = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR  = 7'b1100111;
  localparam logic [6:0] c_OPC_B     = 7'b1100011;
  localparam logic [6:0] c_OPC_LD    = 7'b0000011;
  localparam logic [6:0] c_OPC_S     = 7'b0100011;
  localparam logic [6:0] c_OPC_I     = 7'b0010011;
  localparam logic [6:0] c_OPC_R     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  // Unknown opcodes fall into FMT_R so they carry a zero immediate.
  function automatic imm_fmt_e opc_fmt(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      c_OPC_LUI, c_OPC_AUIPC:          fmt = FMT_U;
      c_OPC_JAL:                       fmt = FMT_J;
      c_OPC_JALR, c_OPC_I, c_OPC_LD:   fmt = FMT_I;
      c_OPC_S:                         fmt = FMT_S;
      c_OPC_B:                         fmt = FMT_B;
      default:                         fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic opc_is_mem(input logic [6:0] opc);
    return (opc == c_OPC_LD) || (opc == c_OPC_S);
  endfunction

  function automatic logic opc_has_rs1(input logic [6:0] opc);
    return !((opc == c_OPC_LUI) || (opc == c_OPC_AUIPC) || (opc == c_OPC_JAL));
  endfunction

  function automatic logic opc_has_rs2(input logic [6:0] opc);
    return (opc == c_OPC_R) || (opc == c_OPC_S) || (opc == c_OPC_B);
  endfunction

  function automatic logic opc_has_rd(input logic [6:0] opc);
    return !((opc == c_OPC_S) || (opc == c_OPC_B));
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_queue_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen
//  Purpose  : Combinational RV32I immediate decoder, sign-extended to 32 bits.
//  Ports    : i_instr [31:0]  instruction word
//             o_imm   [31:0]  decoded immediate (0 for R-type / unknown)
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (opc_fmt(i_instr[6:0]))
      FMT_U:   o_imm = {i_instr[31:12], 12'b0};
      FMT_J:   o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      FMT_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_queue
//  Purpose  : Circular instruction queue between fetch and issue. Predicts
//             JAL / backward branches at push time and issues the head entry
//             as a registered bundle to the RS or the LSB.
//  Ports    : clk, rst (sync, active-high), rdy (global enable), flush
//             fetch_valid/instr/pc in, fetch_ready out
//             pred_valid/pred_pc out   : fetch redirect pulse
//             rob_full/rs_full/lsb_full: downstream back-pressure
//             reg_id1/2 out, reg_value*/has_dep*/v_rob_id* in: regfile lookup
//             rd_rob_id_in             : next free ROB tag
//             issue_valid/issue_to_lsb + registered bundle outputs
//  Revision : 1.0  initial release
// ============================================================================
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int ROB_W    = ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic             pred_valid,
  output logic [31:0]      pred_pc,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic [4:0]       reg_id1,
  output logic [4:0]       reg_id2,
  input  logic [31:0]      reg_value1_in,
  input  logic [31:0]      reg_value2_in,
  input  logic             has_dep1_in,
  input  logic             has_dep2_in,
  input  logic [ROB_W-1:0] v_rob_id1_in,
  input  logic [ROB_W-1:0] v_rob_id2_in,
  input  logic [ROB_W-1:0] rd_rob_id_in,
  output logic             issue_valid,
  output logic             issue_to_lsb,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [2:0]       op_out,
  output logic [6:0]       type_out,
  output logic [31:0]      imm_out,
  output logic [4:0]       rd_out,
  output logic [31:0]      value1_out,
  output logic [31:0]      value2_out,
  output logic             has_dep1_out,
  output logic             has_dep2_out,
  output logic [ROB_W-1:0] rob_id1_out,
  output logic [ROB_W-1:0] rob_id2_out,
  output logic [ROB_W-1:0] rd_rob_id_out,
  output logic             pred_taken_out
);

  localparam int c_PTR_W = $clog2(IQ_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [31:0]        r_instr [IQ_DEPTH];
  logic [31:0]        r_pc    [IQ_DEPTH];
  logic               r_pt    [IQ_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic [31:0] w_head_instr;
  logic [6:0]  w_head_opc;
  logic [31:0] w_head_imm;
  logic [31:0] w_fetch_imm;
  logic        w_head_mem;
  logic        w_head_rs1;
  logic        w_head_rs2;
  logic        w_head_rd;
  logic        w_unit_full;
  logic        w_push;
  logic        w_pop;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;

  assign w_head_instr = r_instr[r_head];
  assign w_head_opc   = w_head_instr[6:0];
  assign w_head_mem   = opc_is_mem(w_head_opc);
  assign w_head_rs1   = opc_has_rs1(w_head_opc);
  assign w_head_rs2   = opc_has_rs2(w_head_opc);
  assign w_head_rd    = opc_has_rd(w_head_opc);

  assign reg_id1 = w_head_instr[19:15];
  assign reg_id2 = w_head_instr[24:20];

  // Readiness looks only at the registered count, so a full queue refuses a
  // push even when the head is leaving in the same cycle.
  assign fetch_ready = (r_count < c_CNT_W'(IQ_DEPTH));

  assign w_unit_full = w_head_mem ? lsb_full : rs_full;
  assign w_push = fetch_valid && fetch_ready && rdy && !flush;
  assign w_pop  = (r_count != '0) && !rob_full && rdy && !flush && !w_unit_full;

  imm_gen u_imm_head (
    .i_instr (w_head_instr),
    .o_imm   (w_head_imm)
  );

  imm_gen u_imm_fetch (
    .i_instr (fetch_instr),
    .o_imm   (w_fetch_imm)
  );

  // Static prediction: JAL always taken, conditional branches taken only when
  // backward (negative offset). JALR targets are unknown here, so not taken.
  assign w_pred_taken  = (fetch_instr[6:0] == c_OPC_JAL) ||
                         ((fetch_instr[6:0] == c_OPC_B) && w_fetch_imm[31]);
  assign w_pred_target = fetch_pc + w_fetch_imm;

  // Entry storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_tail] <= fetch_instr;
      r_pc[r_tail]    <= fetch_pc;
      r_pt[r_tail]    <= w_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      pred_valid     <= 1'b0;
      pred_pc        <= '0;
      issue_valid    <= 1'b0;
      issue_to_lsb   <= 1'b0;
      instr_out      <= '0;
      pc_out         <= '0;
      op_out         <= '0;
      type_out       <= '0;
      imm_out        <= '0;
      rd_out         <= '0;
      value1_out     <= '0;
      value2_out     <= '0;
      has_dep1_out   <= 1'b0;
      has_dep2_out   <= 1'b0;
      rob_id1_out    <= '0;
      rob_id2_out    <= '0;
      rd_rob_id_out  <= '0;
      pred_taken_out <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        pred_valid  <= 1'b0;
        issue_valid <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + c_PTR_W'(1);
        if (w_pop)  r_head <= r_head + c_PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase

        pred_valid <= w_push && w_pred_taken;
        if (w_push && w_pred_taken) pred_pc <= w_pred_target;

        issue_valid <= w_pop;
        if (w_pop) begin
          issue_to_lsb   <= w_head_mem;
          instr_out      <= w_head_instr;
          pc_out         <= r_pc[r_head];
          op_out         <= w_head_instr[14:12];
          type_out       <= w_head_opc;
          imm_out        <= w_head_imm;
          rd_out         <= w_head_instr[11:7];
          value1_out     <= w_head_rs1 ? reg_value1_in : '0;
          has_dep1_out   <= w_head_rs1 ? has_dep1_in : 1'b0;
          rob_id1_out    <= w_head_rs1 ? v_rob_id1_in : '0;
          // Without rs2 the second operand slot carries the immediate.
          value2_out     <= w_head_rs2 ? reg_value2_in : w_head_imm;
          has_dep2_out   <= w_head_rs2 ? has_dep2_in : 1'b0;
          rob_id2_out    <= w_head_rs2 ? v_rob_id2_in : '0;
          rd_rob_id_out  <= w_head_rd ? rd_rob_id_in : '0;
          pred_taken_out <= r_pt[r_head];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue_queue
//  Purpose  : Directed self-checking bench for decode_issue_queue with a
//             scoreboard of expected issue bundles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_issue_queue;

  localparam int IQ_DEPTH = 4;
  localparam int ROB_W    = 4;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_B   = 7'b1100011, OP_LD    = 7'b0000011,
                         OP_S   = 7'b0100011, OP_I     = 7'b0010011,
                         OP_R   = 7'b0110011;
  localparam logic [ROB_W-1:0] RD_TAG = 4'h9;

  logic clk, rst, rdy, flush;
  logic fetch_valid, fetch_ready, pred_valid;
  logic [31:0] fetch_instr, fetch_pc, pred_pc;
  logic rob_full, rs_full, lsb_full;
  logic [4:0] reg_id1, reg_id2;
  logic [31:0] reg_value1_in, reg_value2_in;
  logic has_dep1_in, has_dep2_in;
  logic [ROB_W-1:0] v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
  logic issue_valid, issue_to_lsb;
  logic [31:0] instr_out, pc_out, imm_out, value1_out, value2_out;
  logic [2:0] op_out;
  logic [6:0] type_out;
  logic [4:0] rd_out;
  logic has_dep1_out, has_dep2_out, pred_taken_out;
  logic [ROB_W-1:0] rob_id1_out, rob_id2_out, rd_rob_id_out;

  decode_issue_queue #(.IQ_DEPTH(IQ_DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
    .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
    .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in),
    .rd_rob_id_in(rd_rob_id_in),
    .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb),
    .instr_out(instr_out), .pc_out(pc_out), .op_out(op_out),
    .type_out(type_out), .imm_out(imm_out), .rd_out(rd_out),
    .value1_out(value1_out), .value2_out(value2_out),
    .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
    .rob_id1_out(rob_id1_out), .rob_id2_out(rob_id2_out),
    .rd_rob_id_out(rd_rob_id_out), .pred_taken_out(pred_taken_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: values derived from the register index.
  always_comb begin
    reg_value1_in = 32'h1000_0000 | 32'(reg_id1);
    reg_value2_in = 32'h2000_0000 | 32'(reg_id2);
    has_dep1_in   = reg_id1[0];
    has_dep2_in   = reg_id2[0];
    v_rob_id1_in  = reg_id1[3:0];
    v_rob_id2_in  = ~reg_id2[3:0];
  end

  typedef struct packed {
    logic [31:0] instr;  logic [31:0] pc;  logic [2:0] op;  logic [6:0] typ;
    logic [31:0] imm;    logic [4:0]  rd;  logic [31:0] v1; logic [31:0] v2;
    logic d1; logic d2;  logic [3:0] r1;   logic [3:0] r2;  logic [3:0] rdrob;
    logic pt; logic lsb;
  } bundle_t;

  bundle_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  logic freeze_chk = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [31:0] imm);
    return {imm[31:12], rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic bundle_t expect_of(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] imm, input logic pt);
    bundle_t e;
    logic [6:0] opc = instr[6:0];
    logic [4:0] rs1 = instr[19:15];
    logic [4:0] rs2 = instr[24:20];
    logic h1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    logic h2 = (opc == OP_R || opc == OP_S || opc == OP_B);
    logic hd = !(opc == OP_S || opc == OP_B);
    e.instr = instr;  e.pc = pc;  e.op = instr[14:12];  e.typ = opc;
    e.imm   = imm;    e.rd = instr[11:7];
    e.v1    = h1 ? (32'h1000_0000 | 32'(rs1)) : 32'h0;
    e.d1    = h1 ? rs1[0] : 1'b0;
    e.r1    = h1 ? rs1[3:0] : 4'h0;
    e.v2    = h2 ? (32'h2000_0000 | 32'(rs2)) : imm;
    e.d2    = h2 ? rs2[0] : 1'b0;
    e.r2    = h2 ? ~rs2[3:0] : 4'h0;
    e.rdrob = hd ? RD_TAG : 4'h0;
    e.pt    = pt;
    e.lsb   = (opc == OP_LD || opc == OP_S);
    return e;
  endfunction

  function automatic bundle_t obs_bundle();
    bundle_t o;
    o.instr = instr_out;  o.pc = pc_out;  o.op = op_out;  o.typ = type_out;
    o.imm = imm_out;  o.rd = rd_out;  o.v1 = value1_out;  o.v2 = value2_out;
    o.d1 = has_dep1_out;  o.d2 = has_dep2_out;  o.r1 = rob_id1_out;
    o.r2 = rob_id2_out;  o.rdrob = rd_rob_id_out;  o.pt = pred_taken_out;
    o.lsb = issue_to_lsb;
    return o;
  endfunction

  // One clock; any issue pulse is matched against the scoreboard head.
  task automatic tick();
    @(posedge clk);
    #1;
    if (issue_valid && !freeze_chk) begin
      if (sb.size() == 0) chk("unexpected_issue", issue_valid, 0);
      else chk("issue_bundle", obs_bundle(), sb.pop_front());
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm, input logic pt,
                      input logic [31:0] tgt, input string tag);
    chk({tag, "_ready"}, fetch_ready, 1);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc    = pc;
    sb.push_back(expect_of(instr, pc, imm, pt));
    tick();
    fetch_valid = 1'b0;
    chk({tag, "_pred_valid"}, pred_valid, pt);
    if (pt) chk({tag, "_pred_pc"}, pred_pc, tgt);
  endtask

  task automatic drain(input string tag);
    int budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;  rdy = 1'b1;  flush = 1'b0;
    fetch_valid = 1'b0;  fetch_instr = '0;  fetch_pc = '0;
    rob_full = 1'b0;  rs_full = 1'b0;  lsb_full = 1'b0;
    rd_rob_id_in = RD_TAG;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_pc", pred_pc, 0);
    chk("rst_bundle", obs_bundle(), 0);

    // JAL +16 at 0x100: redirect to 0x110, issued with pred_taken.
    push(enc_j(5'd1, 32'd16), 32'h100, 32'd16, 1'b1, 32'h110, "jal");
    tick();
    chk("jal_pred_pulse_end", pred_valid, 0);

    // Mixed classes: backward/forward branches, JALR, U-types, store, R, load.
    push(enc_b(3'b000, 5'd1, 5'd2, 32'hFFFF_FFF8), 32'h200, 32'hFFFF_FFF8, 1'b1, 32'h1F8, "beq_back");
    push(enc_b(3'b001, 5'd3, 5'd4, 32'd8), 32'h204, 32'd8, 1'b0, 32'h0, "bne_fwd");
    push(enc_i(OP_JALR, 3'b000, 5'd1, 5'd5, 32'd12), 32'h208, 32'd12, 1'b0, 32'h0, "jalr");
    push(enc_u(OP_LUI, 5'd7, 32'hABCD_E000), 32'h20C, 32'hABCD_E000, 1'b0, 32'h0, "lui");
    push(enc_u(OP_AUIPC, 5'd8, 32'h1234_5000), 32'h210, 32'h1234_5000, 1'b0, 32'h0, "auipc");
    push(enc_s(3'b010, 5'd10, 5'd9, 32'hFFFF_FFFC), 32'h214, 32'hFFFF_FFFC, 1'b0, 32'h0, "sw");
    push(enc_r(3'b000, 5'd11, 5'd12, 5'd13), 32'h218, 32'h0, 1'b0, 32'h0, "add");
    push(enc_i(OP_LD, 3'b010, 5'd14, 5'd15, 32'd20), 32'h21C, 32'd20, 1'b0, 32'h0, "lw");
    drain("mix");

    // LSB back-pressure fills the queue; release gives a 4-cycle burst.
    lsb_full = 1'b1;
    for (int i = 0; i < 4; i++)
      push(enc_i(OP_LD, 3'b010, 5'(i + 1), 5'd2, 32'(i * 4)), 32'h300 + 32'(i * 4),
           32'(i * 4), 1'b0, 32'h0, "ld_fill");
    chk("full_not_ready", fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blocked_no_issue", issue_valid, 0);
    end
    lsb_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_issue_valid", issue_valid, 1);
    end
    tick();
    chk("burst_end", issue_valid, 0);

    // ALU op is not held back by a full LSB.
    lsb_full = 1'b1;
    push(enc_i(OP_I, 3'b000, 5'd5, 5'd6, 32'hFFFF_FFFD), 32'h400, 32'hFFFF_FFFD, 1'b0, 32'h0, "addi");
    tick();
    chk("addi_issue_valid", issue_valid, 1);
    chk("addi_to_lsb", issue_to_lsb, 0);
    chk("addi_value2", value2_out, 32'hFFFF_FFFD);
    chk("addi_dep2", has_dep2_out, 0);
    lsb_full = 1'b0;

    // ROB and RS back-pressure each block an ALU op.
    rob_full = 1'b1;
    push(enc_i(OP_I, 3'b000, 5'd3, 5'd4, 32'd1), 32'h410, 32'd1, 1'b0, 32'h0, "robfull");
    tick();
    chk("robfull_block", issue_valid, 0);
    rob_full = 1'b0;
    rs_full  = 1'b1;
    tick();
    chk("rsfull_block", issue_valid, 0);
    rs_full = 1'b0;
    drain("backpressure");

    // Flush with 3 queued entries and a simultaneous JAL push.
    lsb_full = 1'b1;
    for (int i = 0; i < 3; i++)
      push(enc_i(OP_LD, 3'b000, 5'd1, 5'd2, 32'(i)), 32'h500 + 32'(i * 4),
           32'(i), 1'b0, 32'h0, "ld_preflush");
    flush = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = enc_j(5'd1, 32'd16);
    fetch_pc = 32'h510;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    sb.delete();
    chk("flush_issue_valid", issue_valid, 0);
    chk("flush_pred_valid", pred_valid, 0);
    chk("flush_ready", fetch_ready, 1);
    lsb_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_empty", issue_valid, 0);
    end

    // rdy low freezes the issue pulse and bundle and blocks pushes.
    push(enc_i(OP_I, 3'b000, 5'd6, 5'd7, 32'd33), 32'h600, 32'd33, 1'b0, 32'h0, "rdy_a");
    push(enc_i(OP_I, 3'b000, 5'd8, 5'd9, 32'd44), 32'h604, 32'd44, 1'b0, 32'h0, "rdy_b");
    rdy = 1'b0;
    freeze_chk = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = enc_i(OP_I, 3'b000, 5'd10, 5'd11, 32'd55);
    fetch_pc = 32'h608;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_issue_valid", issue_valid, 1);
      chk("hold_instr", instr_out, enc_i(OP_I, 3'b000, 5'd6, 5'd7, 32'd33));
    end
    fetch_valid = 1'b0;
    freeze_chk = 1'b0;
    rdy = 1'b1;
    drain("rdy");
    tick();
    tick();
    chk("rdy_no_push", issue_valid, 0);

    // Full queue: pop plus attempted push in one cycle -> push refused.
    lsb_full = 1'b1;
    for (int i = 0; i < 4; i++)
      push(enc_i(OP_LD, 3'b100, 5'(i + 3), 5'd1, 32'(i + 8)), 32'h700 + 32'(i * 4),
           32'(i + 8), 1'b0, 32'h0, "ld_full");
    chk("full2_not_ready", fetch_ready, 0);
    lsb_full = 1'b0;
    fetch_valid = 1'b1;
    fetch_instr = enc_i(OP_I, 3'b000, 5'd1, 5'd0, 32'd99);
    fetch_pc = 32'h7F0;
    tick();
    fetch_valid = 1'b0;
    lsb_full = 1'b1;
    chk("swap_pop_issue", issue_valid, 1);
    chk("swap_ready", fetch_ready, 1);
    push(enc_i(OP_I, 3'b000, 5'd2, 5'd0, 32'd7), 32'h720, 32'd7, 1'b0, 32'h0, "refill");
    chk("refill_full", fetch_ready, 0);
    lsb_full = 1'b0;
    drain("full_swap");
    tick();
    chk("swap_reject", issue_valid, 0);

    // Ten back-to-back pushes wrap both pointers; FIFO order checked.
    for (int i = 0; i < 10; i++)
      push(enc_i(OP_I, 3'b000, 5'(i + 1), 5'(i), 32'(i + 1)), 32'h800 + 32'(i * 4),
           32'(i + 1), 1'b0, 32'h0, "wrap");
    drain("wrap");

    // Reset mid-operation discards queued loads.
    lsb_full = 1'b1;
    push(enc_i(OP_LD, 3'b010, 5'd1, 5'd2, 32'd0), 32'h900, 32'd0, 1'b0, 32'h0, "ld_prerst");
    push(enc_i(OP_LD, 3'b010, 5'd3, 5'd2, 32'd4), 32'h904, 32'd4, 1'b0, 32'h0, "ld_prerst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    lsb_full = 1'b0;
    chk("midrst_issue_valid", issue_valid, 0);
    chk("midrst_bundle", obs_bundle(), 0);
    push(enc_i(OP_I, 3'b000, 5'd4, 5'd5, 32'd3), 32'h910, 32'd3, 1'b0, 32'h0, "post_rst");
    drain("post_rst");
    tick();
    tick();
    chk("midrst_discard", issue_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 4, number of instruction-queue entries (power of two, 2..16).
REQ-002 Parameter ROB_W, default 4, ROB index width (equals ROB_SIZE_WIDTH).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; low freezes all state and outputs.
REQ-006 flush  in  1  misprediction clear from ROB.
REQ-007 fetch_valid / fetch_instr / fetch_pc  in  1/32/32  instruction from fetcher.
REQ-008 fetch_ready  out  1  queue can accept a push this cycle.
REQ-009 pred_valid / pred_pc  out  1/32  fetch redirect on predicted-taken control flow.
REQ-010 rob_full / rs_full / lsb_full  in  1 each  downstream back-pressure.
REQ-011 reg_id1 / reg_id2  out  5 each  head-entry rs1/rs2 to register file, combinational.
REQ-012 reg_value1_in / reg_value2_in, has_dep1_in / has_dep2_in, v_rob_id1_in / v_rob_id2_in  in  32/32, 1/1, ROB_W/ROB_W  register-file lookup result.
REQ-013 rd_rob_id_in  in  ROB_W  next free ROB tag.
REQ-014 issue_valid  out  1  one-cycle pulse, issued bundle valid.
REQ-015 issue_to_lsb  out  1  1 = load/store (LSB), 0 = RS.
REQ-016 Issued bundle out, registered: instr_out 32, pc_out 32, op_out 3, type_out 7, imm_out 32, rd_out 5, value1_out 32, value2_out 32, has_dep1_out 1, has_dep2_out 1, rob_id1_out ROB_W, rob_id2_out ROB_W, rd_rob_id_out ROB_W, pred_taken_out 1.

Function
REQ-017 Queue is a circular FIFO; head/tail pointers wrap modulo IQ_DEPTH; count 0..IQ_DEPTH.
REQ-018 fetch_ready = (count < IQ_DEPTH), from registered count only; no push at full even with simultaneous pop.
REQ-019 Push when fetch_valid && fetch_ready && rdy && !flush; entry stores instr, pc, pred_taken.
REQ-020 Prediction at push: JAL taken, target pc+immJ; B-type taken iff immB negative, target pc+immB; all others (incl. JALR) not taken.
REQ-021 On taken push, pred_valid=1 and pred_pc=target next cycle, one-cycle pulse; otherwise pred_valid=0.
REQ-022 Pop when count>0 && !rob_full && rdy && !flush && !(target unit full); target unit = LSB for load/store opcodes, RS otherwise.
REQ-023 Pop registers the bundle, issue_valid=1 next cycle (latency 1 from head-ready); otherwise issue_valid=0, bundle holds.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 Immediate generation per opcode class (LUI/AUIPC U, JAL J, JALR/I/load I, S, B, R = 0), sign-extended to 32.
REQ-026 has_rs2 for R/S/B; else value2_out=imm, has_dep2_out=0, rob_id2_out=0.
REQ-027 LUI/AUIPC/JAL have no rs1: value1_out=0, has_dep1_out=0, rob_id1_out=0.
REQ-028 has_rd false for S/B: rd_rob_id_out=0; else rd_rob_id_in.
REQ-029 flush: count=0, head=tail=0, issue_valid=0 and pred_valid=0 next cycle; overrides push and pop in same cycle.
REQ-030 rdy low: no push, no pop, pulses hold their current value.

Reset
REQ-031 rst: count, head, tail = 0; issue_valid, pred_valid = 0; pred_pc and all bundle outputs = 0; queue contents don't-care.
REQ-032 rst mid-operation discards all queued entries; first push accepted the cycle after rst deasserts.

Structure
REQ-033 Opcode-class constants (LUI, AUIPC, JAL, JALR, B, LD, S, I, R) and ROB_SIZE_WIDTH live in the shared config include.
REQ-034 One sub-module imm_gen (instr in, 32-bit imm out, combinational), also used for prediction targets.

Verification
REQ-035 Push JAL imm=+16 at pc 0x100 -> pred_valid pulse, pred_pc=0x110; issue with pred_taken_out=1.
REQ-036 Push BEQ imm=-8 at 0x200 -> pred_pc=0x1F8; BNE imm=+8 -> no pred_valid.
REQ-037 IQ_DEPTH=4, lsb_full=1, push 4 loads -> fetch_ready=0 after 4th, no issue; release -> 4 issues on 4 consecutive cycles, issue_to_lsb=1.
REQ-038 lsb_full=1, head ADDI -> issues to RS, issue_to_lsb=0, value2_out=imm, has_dep2_out=0.
REQ-039 Queue holding 3 entries, flush with fetch_valid=1 -> count=0, no issue, no push next cycle.
REQ-040 Full queue, pop+push same cycle -> push rejected, count=3; tail wrap over 10 pushes keeps FIFO order.
